riscv_prog_loader: RTL and testbench

- Parametrised host-to-core program loader engine.
- Accepts a load command (start address, beat count) plus a data stream from the host.
- Issues per-beat AW/W writes into the RISC-V RAM reload port, tracks outstanding B responses, and holds the core in reset while a load is in progress.
- Sits between the host CSR/stream logic and the core wrapper's ram-reload interface.

---
 rtl/riscv_prog_loader.sv | 190 +++++++++++++++++++
 tb/tb_riscv_prog_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_prog_loader.sv
`default_nettype none
//==============================================================================
// riscv_prog_loader - streams host beats into the RISC-V RAM reload port (AW/W/B)
// and holds the core in reset while loading. Option: PROG_LOADER_CHECKSUM_EN.
// Revision: 1.0
//==============================================================================
module riscv_prog_loader #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 15,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      axi4_mm_clk,
  input  logic                      axi4_mm_rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [LEN_WIDTH-1:0]      cmd_beats,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic [DATA_WIDTH/8-1:0]   s_strb,
  output logic                      m_aw_valid,
  input  logic                      m_aw_ready,
  output logic [ADDR_WIDTH-1:0]     m_aw_addr,
  output logic                      m_w_valid,
  input  logic                      m_w_ready,
  output logic [DATA_WIDTH-1:0]     m_w_data,
  output logic [DATA_WIDTH/8-1:0]   m_w_strb,
  output logic                      m_w_last,
  input  logic                      m_b_valid,
  output logic                      m_b_ready,
  input  logic [1:0]                m_b_resp,
  output logic                      load_en,
  output logic                      core_reset,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      overflow
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]               checksum
`endif
);

  localparam int c_BYTES = DATA_WIDTH / 8;
  localparam int c_OW    = 4;
  localparam logic [c_OW-1:0]       c_MAX_OUT    = c_OW'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ~ADDR_WIDTH'(c_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state, w_next;
  logic                    r_cmd_ready, r_boot, r_aw_pend, r_w_pend, r_err, r_overflow;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LEN_WIDTH-1:0]    r_remaining;
  logic [c_OW-1:0]         r_outstanding;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [c_BYTES-1:0]      r_strb;

  logic                    w_cmd_hs, w_s_hs, w_aw_hs, w_w_hs, w_b_hs, w_b_stray;
  logic                    w_stage_full, w_free;
  logic [ADDR_WIDTH:0]     w_addr_sum;

  assign w_stage_full = r_aw_pend | r_w_pend;
  assign w_cmd_hs     = cmd_valid & r_cmd_ready;
  assign w_s_hs       = s_valid & s_ready;
  assign w_aw_hs      = r_aw_pend & m_aw_ready;
  assign w_w_hs       = r_w_pend & m_w_ready;
  assign w_b_hs       = m_b_valid;
  assign w_b_stray    = w_b_hs & (r_outstanding == '0);
  // The stage frees on the edge where the last of its two channels completes.
  assign w_free       = w_stage_full & (~r_aw_pend | m_aw_ready) & (~r_w_pend | m_w_ready);
  assign w_addr_sum   = {1'b0, r_addr} + (ADDR_WIDTH + 1)'(c_BYTES);

  assign s_ready    = (r_state == S_LOAD) & ~w_stage_full & (r_remaining != '0)
                    & (r_outstanding < c_MAX_OUT);
  assign cmd_ready  = r_cmd_ready;
  assign m_aw_valid = r_aw_pend;
  assign m_aw_addr  = r_addr;
  assign m_w_valid  = r_w_pend;
  assign m_w_data   = r_data;
  assign m_w_strb   = r_strb;
  assign m_w_last   = 1'b1;
  assign m_b_ready  = 1'b1;
  assign err        = r_err;
  assign overflow   = r_overflow;

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_boot        <= 1'b1;
      r_aw_pend     <= 1'b0;
      r_w_pend      <= 1'b0;
      r_err         <= 1'b0;
      r_overflow    <= 1'b0;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
      r_data        <= '0;
      r_strb        <= '0;
    end else begin
      r_state     <= w_next;
      r_cmd_ready <= (w_next == S_IDLE);
      if (r_state == S_DONE) r_boot <= 1'b0;
      if (w_cmd_hs) begin
        r_addr      <= cmd_addr & c_ALIGN_MASK;
        r_remaining <= cmd_beats;
      end else if (w_free) begin
        r_addr      <= w_addr_sum[ADDR_WIDTH-1:0];
        r_remaining <= r_remaining - LEN_WIDTH'(1);
      end
      if (w_s_hs) begin
        r_data    <= s_data;
        r_strb    <= s_strb;
        r_aw_pend <= 1'b1;
        r_w_pend  <= 1'b1;
      end else begin
        if (w_aw_hs) r_aw_pend <= 1'b0;
        if (w_w_hs)  r_w_pend  <= 1'b0;
      end
      if (w_cmd_hs)                            r_overflow <= 1'b0;
      else if (w_free && w_addr_sum[ADDR_WIDTH]) r_overflow <= 1'b1;
      if (w_b_hs && (w_b_stray || m_b_resp != 2'b00)) r_err <= 1'b1;
      else if (w_cmd_hs)                              r_err <= 1'b0;
      // A stray B (nothing outstanding) is dropped rather than underflowing.
      case ({w_aw_hs, w_b_hs & ~w_b_stray})
        2'b10:   r_outstanding <= r_outstanding + c_OW'(1);
        2'b01:   r_outstanding <= r_outstanding - c_OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    load_en    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    core_reset = r_boot;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_cmd_hs) w_next = (cmd_beats == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        load_en    = 1'b1;
        core_reset = 1'b1;
        if (r_remaining == '0 && !w_stage_full) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        load_en    = 1'b1;
        core_reset = 1'b1;
        if (r_outstanding == '0) w_next = S_DONE;
      end
      default: begin
        done       = 1'b1;
        core_reset = 1'b0;
        w_next     = S_IDLE;
      end
    endcase
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum, w_fold;

  always_comb begin
    w_fold = '0;
    for (int i = 0; i < c_BYTES; i++) begin
      if (s_strb[i]) w_fold[(i % 4) * 8 +: 8] = w_fold[(i % 4) * 8 +: 8] ^ s_data[i * 8 +: 8];
    end
  end

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst)   r_checksum <= '0;
    else if (w_cmd_hs) r_checksum <= '0;
    else if (w_s_hs)   r_checksum <= r_checksum ^ w_fold;
  end

  assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_prog_loader.sv
`default_nettype none
// Testbench for riscv_prog_loader: randomized host/AXI traffic against an address/data model.
module tb_riscv_prog_loader;
  localparam int DW = 512, AW = 15, LW = 16, MO = 4, BY = DW / 8;

  logic clk = 1'b0, rst;
  logic cmd_valid, cmd_ready, s_valid, s_ready, m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
  logic m_w_last, m_b_valid, m_b_ready, load_en, core_reset, busy, done, err, overflow;
  logic [AW-1:0] cmd_addr, m_aw_addr;
  logic [LW-1:0] cmd_beats;
  logic [DW-1:0] s_data, m_w_data;
  logic [BY-1:0] s_strb, m_w_strb;
  logic [1:0]    m_b_resp;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]   checksum, cs_at_done;
`endif

  always #5 clk = ~clk;

  riscv_prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MO)) dut (
    .axi4_mm_clk(clk), .axi4_mm_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_strb(s_strb),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_w_last(m_w_last), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp),
    .load_en(load_en), .core_reset(core_reset), .busy(busy), .done(done), .err(err),
    .overflow(overflow)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int checks = 0, errors = 0;
  int q_aw[$];
  logic [DW-1:0] q_wd[$];
  logic [BY-1:0] q_ws[$];
  logic [DW-1:0] src_d[0:31];
  logic [BY-1:0] src_s[0:31];
  int n_done, n_s_hs, n_b, done_dly, aw_at_rel, stab_viol, srdy_viol;
  logic timed_out, srdy_at_rel, cr_at_done, cr_before_done, ovf_end, err_end;

  // Reference model: beat i of a load lands at aligned start + i*BYTES, modulo the RAM size.
  function automatic int exp_addr(input int a, input int i);
    return (((a % (1 << AW)) & ~(BY - 1)) + i * BY) % (1 << AW);
  endfunction

  function automatic bit exp_ovf(input int a, input int n);
    return (((a % (1 << AW)) & ~(BY - 1)) + n * BY) >= (1 << AW);
  endfunction

`ifdef PROG_LOADER_CHECKSUM_EN
  function automatic logic [31:0] exp_cs(input int n);
    logic [31:0] c = '0;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < BY; k++)
        if (src_s[i][k]) c[(k % 4) * 8 +: 8] = c[(k % 4) * 8 +: 8] ^ src_d[i][k * 8 +: 8];
    return c;
  endfunction
`endif

  // Drives one command plus its host stream and AXI slave responses, recording what the DUT does.
  task automatic run_cmd(input int addr, input int beats, input int rdy_pct, input int aw_delay,
                         input int b_hold, input int bad_b, input int abort_aw);
    int cyc = 0, hs_cyc = 0, b_pend = 0, aw_wait = 0, s_idx = 0, post = 0;
    bit taken = 0, stop = 0, aborted = 0, aw_st = 0, w_st = 0;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_d;
    logic cr_prev = 1'b1;
    q_aw.delete(); q_wd.delete(); q_ws.delete();
    n_done = 0; n_s_hs = 0; n_b = 0; done_dly = -1; aw_at_rel = -1; stab_viol = 0; srdy_viol = 0;
    timed_out = 0; srdy_at_rel = 0; cr_at_done = 1'bx; cr_before_done = 1'bx;
    for (int i = 0; i < beats + 2; i++) begin
      for (int k = 0; k < DW / 32; k++) src_d[i][k * 32 +: 32] = $urandom;
      src_s[i] = ($urandom_range(3) == 0) ? BY'({$urandom, $urandom}) : '1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = AW'(addr); cmd_beats = LW'(beats);
    s_valid = 1'b1; s_data = src_d[0]; s_strb = src_s[0];
    m_aw_ready = (aw_delay > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
    m_w_ready = ($urandom_range(99) < rdy_pct);
    m_b_valid = 1'b0; m_b_resp = 2'd0;
    while (!stop) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin taken = 1; hs_cyc = cyc; end
      if (aw_st && (!m_aw_valid || m_aw_addr !== st_addr)) stab_viol++;
      if (w_st && (!m_w_valid || m_w_data !== st_d)) stab_viol++;
      aw_st = m_aw_valid && !m_aw_ready; st_addr = m_aw_addr;
      w_st = m_w_valid && !m_w_ready; st_d = m_w_data;
      if (s_ready && (m_aw_valid || m_w_valid || (q_aw.size() - n_b) >= MO)) srdy_viol++;
      if (cyc == b_hold) begin aw_at_rel = q_aw.size(); srdy_at_rel = s_ready; end
      if (s_valid && s_ready) begin n_s_hs++; s_idx++; end
      if (m_aw_valid && m_aw_ready) begin q_aw.push_back(int'(m_aw_addr)); b_pend++; aw_wait = 0; end
      else if (m_aw_valid) aw_wait++;
      if (m_w_valid && m_w_ready) begin q_wd.push_back(m_w_data); q_ws.push_back(m_w_strb); end
      if (m_b_valid) begin b_pend--; n_b++; end
      if (done) begin
        n_done++; cr_at_done = core_reset; cr_before_done = cr_prev; done_dly = cyc - hs_cyc;
`ifdef PROG_LOADER_CHECKSUM_EN
        cs_at_done = checksum;
`endif
      end
      cr_prev = core_reset;
      if (n_done > 0) post++;
      if (post >= 3) stop = 1;
      if (abort_aw > 0 && q_aw.size() >= abort_aw) begin aborted = 1; stop = 1; end
      if (cyc >= 3000) begin timed_out = 1; stop = 1; end
      if (!stop) begin
        @(posedge clk); #1;
        cyc++;
        if (taken) cmd_valid = 1'b0;
        s_valid = (s_idx < beats + 2);
        if (s_valid) begin s_data = src_d[s_idx]; s_strb = src_s[s_idx]; end
        m_aw_ready = (aw_delay > 0) ? (aw_wait >= aw_delay) : ($urandom_range(99) < rdy_pct);
        m_w_ready = ($urandom_range(99) < rdy_pct);
        m_b_valid = (b_pend > 0) && (cyc >= b_hold) && ($urandom_range(99) < rdy_pct);
        m_b_resp = (m_b_valid && n_b == bad_b) ? 2'd2 : 2'd0;
      end
    end
    ovf_end = overflow; err_end = err;
    if (!aborted) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0; s_valid = 1'b0; m_b_valid = 1'b0; m_b_resp = 2'd0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({cmd_ready, s_ready, m_aw_valid, m_w_valid, load_en, busy, done, err, overflow} !== 9'b0) begin errors++; $display("FAIL reset_low got %b exp 000000000", {cmd_ready, s_ready, m_aw_valid, m_w_valid, load_en, busy, done, err, overflow}); end
    checks++; if ({core_reset, m_b_ready, m_w_last} !== 3'b111) begin errors++; $display("FAIL reset_high got %b exp 111", {core_reset, m_b_ready, m_w_last}); end
    checks++; if (m_aw_addr !== '0 || m_w_data !== '0 || m_w_strb !== '0) begin errors++; $display("FAIL reset_regs got addr %0h exp 0", m_aw_addr); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_cmd(32'h40, 3, 100, 0, 0, -1, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got 1 exp 0"); end
    checks++; if (q_aw.size() !== 3) begin errors++; $display("FAIL basic_aw_count got %0d exp 3", q_aw.size()); end
    for (int i = 0; i < 3 && i < q_aw.size(); i++) begin
      checks++; if (q_aw[i] !== 32'h40 * (i + 1)) begin errors++; $display("FAIL basic_addr[%0d] got %0h exp %0h", i, q_aw[i], 32'h40 * (i + 1)); end
    end
    for (int i = 0; i < 3 && i < q_wd.size(); i++) begin
      checks++; if (q_wd[i] !== src_d[i] || q_ws[i] !== src_s[i]) begin errors++; $display("FAIL basic_data[%0d] got %0h exp %0h", i, q_wd[i], src_d[i]); end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", n_done); end
    checks++; if (err_end !== 1'b0 || ovf_end !== 1'b0) begin errors++; $display("FAIL basic_err_ovf got %b%b exp 00", err_end, ovf_end); end
    checks++; if ({cr_before_done, cr_at_done} !== 2'b10) begin errors++; $display("FAIL basic_core_reset_fall got %b exp 10", {cr_before_done, cr_at_done}); end
    checks++; if ({cmd_ready, core_reset, busy} !== 3'b100) begin errors++; $display("FAIL basic_idle_after got %b exp 100", {cmd_ready, core_reset, busy}); end
`ifdef PROG_LOADER_CHECKSUM_EN
    checks++; if (cs_at_done !== exp_cs(3)) begin errors++; $display("FAIL basic_checksum got %0h exp %0h", cs_at_done, exp_cs(3)); end
`endif
  endtask

  task automatic test_zero_beats();
    run_cmd(int'($urandom_range(32767)), 0, 100, 0, 0, -1, 0);
    checks++; if (q_aw.size() !== 0 || q_wd.size() !== 0) begin errors++; $display("FAIL zero_traffic got %0d exp 0", q_aw.size() + q_wd.size()); end
    checks++; if (n_s_hs !== 0) begin errors++; $display("FAIL zero_s_consumed got %0d exp 0", n_s_hs); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL zero_done_count got %0d exp 1", n_done); end
    checks++; if (done_dly < 1 || done_dly > 2) begin errors++; $display("FAIL zero_done_latency got %0d exp 1..2", done_dly); end
  endtask

  task automatic test_outstanding();
    int a = int'($urandom_range(255)) * BY;
    run_cmd(a, 6, 100, 0, 80, -1, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL outst_timeout got 1 exp 0"); end
    checks++; if (aw_at_rel !== MO) begin errors++; $display("FAIL outst_aw_while_held got %0d exp %0d", aw_at_rel, MO); end
    checks++; if (srdy_at_rel !== 1'b0) begin errors++; $display("FAIL outst_s_ready_held got %b exp 0", srdy_at_rel); end
    checks++; if (q_aw.size() !== 6 || n_b !== 6) begin errors++; $display("FAIL outst_totals got aw %0d b %0d exp 6 6", q_aw.size(), n_b); end
    checks++; if (n_done !== 1 || n_s_hs !== 6) begin errors++; $display("FAIL outst_done got done %0d beats %0d exp 1 6", n_done, n_s_hs); end
    checks++; if (srdy_viol !== 0) begin errors++; $display("FAIL outst_s_ready_rule got %0d exp 0", srdy_viol); end
  endtask

  task automatic test_aw_delay();
    int a = int'($urandom_range(32767));
    run_cmd(a, 4, 100, 3, 0, -1, 0);
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL awdly_stable got %0d exp 0", stab_viol); end
    checks++; if (srdy_viol !== 0) begin errors++; $display("FAIL awdly_stage_hold got %0d exp 0", srdy_viol); end
    checks++; if (q_aw.size() !== 4 || n_done !== 1) begin errors++; $display("FAIL awdly_count got %0d exp 4", q_aw.size()); end
    for (int i = 0; i < 4 && i < q_aw.size() && i < q_wd.size(); i++) begin
      checks++; if (q_aw[i] !== exp_addr(a, i) || q_wd[i] !== src_d[i]) begin errors++; $display("FAIL awdly_beat[%0d] got addr %0h exp %0h", i, q_aw[i], exp_addr(a, i)); end
    end
  endtask

  task automatic test_wrap();
    run_cmd(32'h7FC0, 2, 100, 0, 0, 0, 0);
    checks++; if (q_aw.size() !== 2) begin errors++; $display("FAIL wrap_count got %0d exp 2", q_aw.size()); end
    for (int i = 0; i < 2 && i < q_aw.size(); i++) begin
      checks++; if (q_aw[i] !== exp_addr(32'h7FC0, i)) begin errors++; $display("FAIL wrap_addr[%0d] got %0h exp %0h", i, q_aw[i], exp_addr(32'h7FC0, i)); end
    end
    checks++; if (ovf_end !== 1'b1) begin errors++; $display("FAIL wrap_overflow got %b exp 1", ovf_end); end
    checks++; if (err_end !== 1'b1) begin errors++; $display("FAIL wrap_err got %b exp 1", err_end); end
    run_cmd(32'h100, 1, 100, 0, 0, -1, 0);
    checks++; if ({ovf_end, err_end} !== 2'b00) begin errors++; $display("FAIL wrap_clear got %b exp 00", {ovf_end, err_end}); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int a = int'($urandom_range(32767));
      int n = int'($urandom_range(1, 8));
      int bad = ($urandom_range(1) == 1) ? int'($urandom_range(n - 1)) : -1;
      run_cmd(a, n, 60, 0, 0, bad, 0);
      checks++; if (timed_out || n_done !== 1) begin errors++; $display("FAIL rand%0d_done got %0d exp 1", t, n_done); end
      checks++; if (q_aw.size() !== n || q_wd.size() !== n || n_b !== n) begin errors++; $display("FAIL rand%0d_count got %0d/%0d/%0d exp %0d", t, q_aw.size(), q_wd.size(), n_b, n); end
      for (int i = 0; i < n && i < q_aw.size() && i < q_wd.size(); i++) begin
        checks++; if (q_aw[i] !== exp_addr(a, i) || q_wd[i] !== src_d[i] || q_ws[i] !== src_s[i]) begin errors++; $display("FAIL rand%0d_beat[%0d] got addr %0h exp %0h", t, i, q_aw[i], exp_addr(a, i)); end
      end
      checks++; if (ovf_end !== exp_ovf(a, n)) begin errors++; $display("FAIL rand%0d_overflow got %b exp %b", t, ovf_end, exp_ovf(a, n)); end
      checks++; if (err_end !== (bad >= 0)) begin errors++; $display("FAIL rand%0d_err got %b exp %b", t, err_end, bad >= 0); end
      checks++; if (stab_viol !== 0 || srdy_viol !== 0) begin errors++; $display("FAIL rand%0d_protocol got %0d/%0d exp 0/0", t, stab_viol, srdy_viol); end
    end
  endtask

  task automatic test_reset_midload();
    int act = 0;
    int a = int'($urandom_range(32767));
    run_cmd(int'($urandom_range(32767)), 10, 100, 0, 0, -1, 4);
    #2 rst = 1'b1;
    #1;
    checks++; if ({cmd_ready, s_ready, m_aw_valid, m_w_valid, load_en, busy, done} !== 7'b0) begin errors++; $display("FAIL rstmid_low got %b exp 0000000", {cmd_ready, s_ready, m_aw_valid, m_w_valid, load_en, busy, done}); end
    checks++; if ({core_reset, m_b_ready} !== 2'b11) begin errors++; $display("FAIL rstmid_high got %b exp 11", {core_reset, m_b_ready}); end
    cmd_valid = 1'b0; s_valid = 1'b0; m_b_valid = 1'b0; m_b_resp = 2'd0;
    repeat (3) begin
      @(negedge clk);
      if (m_aw_valid || m_w_valid || busy) act++;
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d exp 0", act); end
    @(posedge clk); #1;
    rst = 1'b0;
    run_cmd(a, 1, 100, 0, 0, -1, 0);
    checks++; if (q_aw.size() !== 1 || n_done !== 1) begin errors++; $display("FAIL rstmid_next got %0d/%0d exp 1/1", q_aw.size(), n_done); end
    if (q_aw.size() > 0 && q_wd.size() > 0) begin
      checks++; if (q_aw[0] !== exp_addr(a, 0) || q_wd[0] !== src_d[0]) begin errors++; $display("FAIL rstmid_beat got addr %0h exp %0h", q_aw[0], exp_addr(a, 0)); end
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    s_valid = 1'b0; s_data = '0; s_strb = '0;
    m_aw_ready = 1'b0; m_w_ready = 1'b0; m_b_valid = 1'b0; m_b_resp = 2'd0;
    test_reset();
    test_basic();
    test_zero_beats();
    test_outstanding();
    test_aw_delay();
    test_wrap();
    test_random();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
